// File: rtl/ac_pkg.sv
// Shared types and constants for the arithmetic-coder stream packer.
// Stream layout: [N][3*(N+1) table bytes][LEN_HI][LEN_LO][LEN payload bytes].
package ac_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        TABLE,
        LEN_HI,
        LEN_LO,
        PAYLOAD,
        FLUSH,
        DONE
    } ac_pack_state_t;

    localparam int AC_ENTRY_BYTES = 3;
    localparam int AC_LEN_BYTES   = 2;
    localparam int AC_WORD_BYTES  = 4;

    // Table size in bytes for a header value N.
    function automatic logic [16:0] table_bytes(input logic [7:0] n);
        return 17'(AC_ENTRY_BYTES) * ({9'd0, n} + 17'd1);
    endfunction

    // Bytes up to and including LEN_LO for a header value N.
    function automatic logic [16:0] hdr_total(input logic [7:0] n);
        return 17'd1 + table_bytes(n) + 17'(AC_LEN_BYTES);
    endfunction

    function automatic logic [3:0] keep_mask(input logic [2:0] nbytes);
        logic [3:0] mask;
        case (nbytes)
            3'd1:    mask = 4'b0001;
            3'd2:    mask = 4'b0011;
            3'd3:    mask = 4'b0111;
            3'd4:    mask = 4'b1111;
            default: mask = 4'b0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/ac_stream_packer_if.sv
// 32-bit AXI-Stream output bundle of the stream packer.
interface ac_stream_packer_if;
    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic        tlast;
    logic        tvalid;
    logic        tready;

    modport master (output tdata, output tkeep, output tlast, output tvalid, input tready);
    modport slave  (input tdata, input tkeep, input tlast, input tvalid, output tready);
endinterface

// File: rtl/ac_byte_fifo.sv
// Small synchronous byte FIFO, first-word-fall-through, with occupancy count.
module ac_byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [7:0]               din,
    input  logic                     pop,
    output logic [7:0]               dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] cnt_r;
    logic          full_s;
    logic          do_push_s;
    logic          do_pop_s;

    assign full_s    = (cnt_r == CW'(DEPTH));
    assign empty     = (cnt_r == {CW{1'b0}});
    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && (!full_s || do_pop_s);
    assign dout      = mem_r[rd_ptr_r];
    assign count     = cnt_r;

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointer and occupancy tracking; push and pop together leave the count unchanged.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            cnt_r    <= {CW{1'b0}};
        end else begin
            if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
            case ({do_push_s, do_pop_s})
                2'b10:   cnt_r <= cnt_r + CW'(1);
                2'b01:   cnt_r <= cnt_r - CW'(1);
                default: cnt_r <= cnt_r;
            endcase
        end
    end
endmodule

// File: rtl/ac_stream_packer.sv
// Drains the arithmetic_coder byte stream, parses it to find its exact end and
// packs it little-endian into 32-bit AXI-Stream words with tlast/tkeep on the final word.
module ac_stream_packer
    import ac_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_LEN    = 4096
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               coder_valid_in,
    input  logic [7:0]         coder_data_in,
    output logic               coder_next_out,
    ac_stream_packer_if.master m,
    output logic               busy_out,
    output logic               done_out,
    output logic               err_out
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int OW = CW + 1;

    ac_pack_state_t state_r;
    logic [16:0] byte_cnt_r, req_cnt_r, limit_r, pop_cnt_r;
    logic [7:0]  len_hi_r;
    logic        next_r, cap_r, need_low_r, total_known_r;
    logic        busy_r, done_r, err_r;
    logic [23:0] asm_data_r;
    logic [1:0]  asm_cnt_r;
    logic [31:0] tdata_r;
    logic [3:0]  tkeep_r;
    logic        tlast_r, tvalid_r;

    logic [7:0]    fifo_dout_s;
    logic [CW-1:0] fifo_cnt_s;
    logic          fifo_empty_s;
    logic [OW-1:0] occ_s;
    logic [15:0]   len_s;
    logic [16:0]   eff_len_s;
    logic [31:0]   word_s;
    logic          in_frame_s, req_s, len_over_s, last_byte_s, out_free_s, pop_s, emit_s;

    ac_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cap_r),
        .din   (coder_data_in),
        .pop   (pop_s),
        .dout  (fifo_dout_s),
        .count (fifo_cnt_s),
        .empty (fifo_empty_s)
    );

    // Request credit, stream-end detection and packer pop/emit decisions.
    always_comb begin
        case (state_r)
            HDR, TABLE, LEN_HI, LEN_LO, PAYLOAD: in_frame_s = 1'b1;
            default:                             in_frame_s = 1'b0;
        endcase
        // Bytes already owed to the FIFO count against its free space.
        occ_s       = OW'(fifo_cnt_s) + OW'(cap_r) + OW'(next_r);
        req_s       = in_frame_s && (req_cnt_r < limit_r) && (occ_s < OW'(FIFO_DEPTH));
        len_s       = {len_hi_r, coder_data_in};
        len_over_s  = (len_s > 16'(MAX_LEN));
        eff_len_s   = len_over_s ? 17'(MAX_LEN) : {1'b0, len_s};
        last_byte_s = total_known_r && ((pop_cnt_r + 17'd1) == limit_r);
        out_free_s  = !tvalid_r || m.tready;
        pop_s       = !fifo_empty_s &&
                      (out_free_s || ((asm_cnt_r != 2'(AC_WORD_BYTES - 1)) && !last_byte_s));
        emit_s      = pop_s && ((asm_cnt_r == 2'(AC_WORD_BYTES - 1)) || last_byte_s);
        case (asm_cnt_r)
            2'd1:    word_s = {16'd0, fifo_dout_s, asm_data_r[7:0]};
            2'd2:    word_s = {8'd0, fifo_dout_s, asm_data_r[15:0]};
            2'd3:    word_s = {fifo_dout_s, asm_data_r[23:0]};
            default: word_s = {24'd0, fifo_dout_s};
        endcase
    end

    // Parser FSM and byte-request generator, advanced on captured bytes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= IDLE;
            byte_cnt_r    <= 17'd0;
            req_cnt_r     <= 17'd0;
            limit_r       <= 17'd0;
            pop_cnt_r     <= 17'd0;
            len_hi_r      <= 8'd0;
            next_r        <= 1'b0;
            cap_r         <= 1'b0;
            need_low_r    <= 1'b0;
            total_known_r <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            err_r         <= 1'b0;
        end else begin
            next_r <= req_s;
            cap_r  <= next_r;
            done_r <= 1'b0;
            if (req_s)           req_cnt_r  <= req_cnt_r + 17'd1;
            if (pop_s)           pop_cnt_r  <= pop_cnt_r + 17'd1;
            if (!coder_valid_in) need_low_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (coder_valid_in && !need_low_r) begin
                        state_r       <= HDR;
                        busy_r        <= 1'b1;
                        need_low_r    <= 1'b1;
                        req_cnt_r     <= 17'd0;
                        pop_cnt_r     <= 17'd0;
                        total_known_r <= 1'b0;
                        // Shortest possible stream until N is known.
                        limit_r       <= hdr_total(8'd0);
                    end
                end
                HDR: begin
                    if (cap_r) begin
                        byte_cnt_r <= table_bytes(coder_data_in);
                        limit_r    <= hdr_total(coder_data_in);
                        state_r    <= TABLE;
                    end
                end
                TABLE: begin
                    if (cap_r) begin
                        byte_cnt_r <= byte_cnt_r - 17'd1;
                        if (byte_cnt_r == 17'd1) state_r <= LEN_HI;
                    end
                end
                LEN_HI: begin
                    if (cap_r) begin
                        len_hi_r <= coder_data_in;
                        state_r  <= LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (cap_r) begin
                        if (len_over_s) err_r <= 1'b1;
                        limit_r       <= limit_r + eff_len_s;
                        total_known_r <= 1'b1;
                        byte_cnt_r    <= eff_len_s;
                        state_r       <= (eff_len_s == 17'd0) ? FLUSH : PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (cap_r) begin
                        byte_cnt_r <= byte_cnt_r - 17'd1;
                        if (byte_cnt_r == 17'd1) state_r <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (tvalid_r && m.tready && tlast_r) begin
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= DONE;
                    end
                end
                DONE:    state_r <= IDLE;
                default: state_r <= IDLE;
            endcase
        end
    end

    // Byte assembly and output word register; assembly continues while a word is held.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            asm_data_r <= 24'd0;
            asm_cnt_r  <= 2'd0;
            tdata_r    <= 32'd0;
            tkeep_r    <= 4'd0;
            tlast_r    <= 1'b0;
            tvalid_r   <= 1'b0;
        end else begin
            if (tvalid_r && m.tready) tvalid_r <= 1'b0;
            if (emit_s) begin
                tdata_r    <= word_s;
                tkeep_r    <= keep_mask({1'b0, asm_cnt_r} + 3'd1);
                tlast_r    <= last_byte_s;
                tvalid_r   <= 1'b1;
                asm_data_r <= 24'd0;
                asm_cnt_r  <= 2'd0;
            end else if (pop_s) begin
                asm_data_r <= word_s[23:0];
                asm_cnt_r  <= asm_cnt_r + 2'd1;
            end
        end
    end

    assign coder_next_out = next_r;
    assign busy_out       = busy_r;
    assign done_out       = done_r;
    assign err_out        = err_r;
    assign m.tdata        = tdata_r;
    assign m.tkeep        = tkeep_r;
    assign m.tlast        = tlast_r;
    assign m.tvalid       = tvalid_r;
endmodule

// File: tb/tb_ac_stream_packer.sv
// Self-checking bench for ac_stream_packer: a coder byte-source model feeds framed
// streams, a packing model built straight from the stream layout predicts the words.
module tb_ac_stream_packer;
    localparam int DEPTH  = 4;
    localparam int MAXL   = 4096;
    localparam int BUDGET = 20000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       coder_valid = 1'b0;
    logic [7:0] coder_data = 8'd0;
    logic       coder_next, busy, done, err;
    logic       tready = 1'b1;

    ac_stream_packer_if m_if();
    assign m_if.tready = tready;

    ac_stream_packer #(.FIFO_DEPTH(DEPTH), .MAX_LEN(MAXL)) dut (
        .clk            (clk),
        .rst            (rst),
        .coder_valid_in (coder_valid),
        .coder_data_in  (coder_data),
        .coder_next_out (coder_next),
        .m              (m_if.master),
        .busy_out       (busy),
        .done_out       (done),
        .err_out        (err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0]  stream[$];
    logic [31:0] exp_data[$];
    logic [3:0]  exp_keep[$];
    logic        exp_last[$];
    logic [31:0] got_data[$];
    logic [3:0]  got_keep[$];
    logic        got_last[$];
    int   exp_total, idx, req_cnt, done_cnt, viol_cnt, ovf_cnt;
    logic rewind = 1'b0;
    int   ready_mode = 0;
    int   ph = 0;

    // Coder model: on a request it presents the next stream byte for the following edge.
    always @(posedge clk) begin
        if (rewind) begin
            idx     <= 0;
            req_cnt <= 0;
        end else if (coder_next) begin
            coder_data <= (idx < stream.size()) ? stream[idx] : 8'hEE;
            idx        <= idx + 1;
            req_cnt    <= req_cnt + 1;
        end
    end

    // Downstream ready pattern.
    always @(negedge clk) begin
        case (ready_mode)
            0:       tready = 1'b1;
            1: begin tready = (ph == 0); ph = (ph == 2) ? 0 : ph + 1; end
            default: tready = 1'($urandom_range(0, 1));
        endcase
    end

    // Output collector plus AXI hold-stability and FIFO overflow watch.
    logic        hold_pend = 1'b0;
    logic [36:0] hold_val  = 37'd0;
    always @(posedge clk) begin
        if (rewind) begin
            got_data.delete(); got_keep.delete(); got_last.delete();
            done_cnt = 0; viol_cnt = 0; ovf_cnt = 0; hold_pend = 1'b0;
        end else begin
            if (hold_pend && (!m_if.tvalid || {m_if.tdata, m_if.tkeep, m_if.tlast} !== hold_val))
                viol_cnt++;
            hold_pend = m_if.tvalid && !m_if.tready;
            hold_val  = {m_if.tdata, m_if.tkeep, m_if.tlast};
            if (m_if.tvalid && m_if.tready) begin
                got_data.push_back(m_if.tdata);
                got_keep.push_back(m_if.tkeep);
                got_last.push_back(m_if.tlast);
            end
            if (done) done_cnt++;
            if (dut.u_fifo.push && dut.u_fifo.full_s && !dut.u_fifo.pop) ovf_cnt++;
        end
    end

    task automatic build_stream(input int n, input int len);
        logic [15:0] l16;
        l16 = 16'(len);
        stream.delete();
        stream.push_back(8'(n));
        for (int i = 0; i < 3 * (n + 1); i++) stream.push_back(8'($urandom));
        stream.push_back(l16[15:8]);
        stream.push_back(l16[7:0]);
        for (int i = 0; i < len; i++) stream.push_back(8'($urandom));
    endtask

    // Reference: the first exp_total stream bytes, four per word, first byte lowest.
    task automatic build_expected(input int n, input int len);
        logic [31:0] d;
        logic [3:0]  k;
        exp_total = 1 + 3 * (n + 1) + 2 + ((len > MAXL) ? MAXL : len);
        exp_data.delete(); exp_keep.delete(); exp_last.delete();
        for (int w = 0; w * 4 < exp_total; w++) begin
            d = 32'd0;
            k = 4'd0;
            for (int b = 0; b < 4; b++) begin
                if (w * 4 + b < exp_total) begin
                    d[8*b +: 8] = stream[w * 4 + b];
                    k[b] = 1'b1;
                end
            end
            exp_data.push_back(d);
            exp_keep.push_back(k);
            exp_last.push_back(w * 4 + 4 >= exp_total);
        end
    endtask

    function automatic int words_bad();
        int bad = 0;
        for (int i = 0; i < got_data.size() && i < exp_data.size(); i++)
            if (got_data[i] !== exp_data[i] || got_keep[i] !== exp_keep[i] || got_last[i] !== exp_last[i])
                bad++;
        return bad;
    endfunction

    task automatic pulse_rewind();
        @(negedge clk) rewind = 1'b1;
        @(negedge clk) rewind = 1'b0;
    endtask

    task automatic run_frame(input int n, input int len, input int mode, input bit reuse,
                             output bit timed_out);
        int cyc = 0;
        if (!reuse) build_stream(n, len);
        build_expected(n, len);
        ready_mode = mode;
        pulse_rewind();
        coder_valid = 1'b1;
        while (done_cnt == 0 && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
        end
        timed_out = (done_cnt == 0);
        repeat (3) @(negedge clk);
        coder_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++; if ({m_if.tvalid, m_if.tlast, m_if.tkeep} !== 6'd0) begin n_bad++; $display("FAIL reset_axi got=%b exp=0", {m_if.tvalid, m_if.tlast, m_if.tkeep}); end
        n_cmp++; if (m_if.tdata !== 32'd0) begin n_bad++; $display("FAIL reset_tdata got=%h exp=0", m_if.tdata); end
        n_cmp++; if ({busy, done, err, coder_next} !== 4'd0) begin n_bad++; $display("FAIL reset_ctrl got=%b exp=0000", {busy, done, err, coder_next}); end
        @(negedge clk) rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        bit to;
        build_stream(0, 0);
        stream[1] = 8'h41; stream[2] = 8'h00; stream[3] = 8'h05;
        run_frame(0, 0, 0, 1'b1, to);
        n_cmp++; if (to) begin n_bad++; $display("FAIL t1_timeout got=no_done exp=done"); end
        n_cmp++; if (got_data.size() !== 2) begin n_bad++; $display("FAIL t1_nwords got=%0d exp=2", got_data.size()); end
        n_cmp++; if (got_data.size() > 0 && (got_data[0] !== 32'h05004100 || got_keep[0] !== 4'hF))
            begin n_bad++; $display("FAIL t1_word0 got=%h/%h exp=05004100/f", got_data[0], got_keep[0]); end
        n_cmp++; if (got_data.size() > 1 && (got_keep[1] !== 4'h3 || got_last[1] !== 1'b1 || got_data[1] !== 32'd0))
            begin n_bad++; $display("FAIL t1_word1 got=%h/%h/%b exp=00000000/3/1", got_data[1], got_keep[1], got_last[1]); end
        n_cmp++; if (req_cnt !== 6) begin n_bad++; $display("FAIL t1_requests got=%0d exp=6", req_cnt); end
        n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL t1_done got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_len7(input int mode, input bit reuse);
        bit to;
        run_frame(2, 7, mode, reuse, to);
        n_cmp++; if (to) begin n_bad++; $display("FAIL t23_timeout mode=%0d got=no_done exp=done", mode); end
        n_cmp++; if (got_data.size() !== 5) begin n_bad++; $display("FAIL t23_nwords got=%0d exp=5", got_data.size()); end
        n_cmp++; if (words_bad() !== 0) begin n_bad++; $display("FAIL t23_words bad=%0d exp=0", words_bad()); end
        n_cmp++; if (got_keep.size() > 0 && got_keep[got_keep.size() - 1] !== 4'b0111)
            begin n_bad++; $display("FAIL t23_lastkeep got=%b exp=0111", got_keep[got_keep.size() - 1]); end
        n_cmp++; if (req_cnt !== 19) begin n_bad++; $display("FAIL t23_requests got=%0d exp=19", req_cnt); end
        n_cmp++; if (ovf_cnt !== 0 || viol_cnt !== 0) begin n_bad++; $display("FAIL t23_protocol ovf=%0d viol=%0d exp=0/0", ovf_cnt, viol_cnt); end
        n_cmp++; if (busy !== 1'b0 || err !== 1'b0) begin n_bad++; $display("FAIL t23_idle busy=%b err=%b exp=0/0", busy, err); end
    endtask

    task automatic test_aligned();
        bit to;
        run_frame(2, 8, 0, 1'b0, to);
        n_cmp++; if (to) begin n_bad++; $display("FAIL t4_timeout got=no_done exp=done"); end
        n_cmp++; if (got_data.size() !== 5) begin n_bad++; $display("FAIL t4_nwords got=%0d exp=5", got_data.size()); end
        n_cmp++; if (words_bad() !== 0) begin n_bad++; $display("FAIL t4_words bad=%0d exp=0", words_bad()); end
        n_cmp++; if (got_data.size() > 0 && (got_keep[got_keep.size() - 1] !== 4'hF || got_last[got_last.size() - 1] !== 1'b1))
            begin n_bad++; $display("FAIL t4_final keep=%h last=%b exp=f/1", got_keep[got_keep.size() - 1], got_last[got_last.size() - 1]); end
    endtask

    task automatic test_overlen();
        bit to;
        run_frame(1, 5000, 0, 1'b0, to);
        n_cmp++; if (to) begin n_bad++; $display("FAIL t5_timeout got=no_done exp=done"); end
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL t5_err got=%b exp=1", err); end
        n_cmp++; if (req_cnt !== 1 + 6 + 2 + 4096) begin n_bad++; $display("FAIL t5_requests got=%0d exp=%0d", req_cnt, 1 + 6 + 2 + 4096); end
        n_cmp++; if (got_data.size() !== 1027) begin n_bad++; $display("FAIL t5_nwords got=%0d exp=1027", got_data.size()); end
        n_cmp++; if (words_bad() !== 0) begin n_bad++; $display("FAIL t5_words bad=%0d exp=0", words_bad()); end
        n_cmp++; if (got_data.size() > 0 && (got_last[got_last.size() - 1] !== 1'b1 || got_keep[got_keep.size() - 1] !== 4'b0001))
            begin n_bad++; $display("FAIL t5_final last=%b keep=%b exp=1/0001", got_last[got_last.size() - 1], got_keep[got_keep.size() - 1]); end
    endtask

    task automatic test_reset_mid();
        bit to;
        int cyc = 0;
        build_stream(1, 40);
        ready_mode = 0;
        pulse_rewind();
        coder_valid = 1'b1;
        while (req_cnt < 20 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL t6_midframe busy=%b exp=1", busy); end
        #2 rst = 1'b0;
        #1;
        n_cmp++; if ({m_if.tvalid, m_if.tlast, m_if.tkeep, m_if.tdata} !== 38'd0)
            begin n_bad++; $display("FAIL t6_axi_zero got=%b/%b/%h/%h exp=0", m_if.tvalid, m_if.tlast, m_if.tkeep, m_if.tdata); end
        n_cmp++; if ({busy, done, err, coder_next} !== 4'd0) begin n_bad++; $display("FAIL t6_ctrl_zero got=%b exp=0000", {busy, done, err, coder_next}); end
        coder_valid = 1'b0;
        pulse_rewind();
        @(negedge clk) rst = 1'b1;
        repeat (8) @(negedge clk);
        n_cmp++; if (got_data.size() !== 0) begin n_bad++; $display("FAIL t6_stray got=%0d words exp=0", got_data.size()); end
        run_frame(3, 13, 2, 1'b0, to);
        n_cmp++; if (to) begin n_bad++; $display("FAIL t6_timeout got=no_done exp=done"); end
        n_cmp++; if (got_data.size() !== exp_data.size()) begin n_bad++; $display("FAIL t6_nwords got=%0d exp=%0d", got_data.size(), exp_data.size()); end
        n_cmp++; if (words_bad() !== 0) begin n_bad++; $display("FAIL t6_words bad=%0d exp=0", words_bad()); end
    endtask

    task automatic test_random();
        bit to;
        int n, len;
        for (int f = 0; f < 4; f++) begin
            n   = int'($urandom_range(0, 5));
            len = int'($urandom_range(0, 33));
            run_frame(n, len, 2, 1'b0, to);
            n_cmp++; if (to) begin n_bad++; $display("FAIL rnd_timeout frame=%0d got=no_done exp=done", f); end
            n_cmp++; if (got_data.size() !== exp_data.size()) begin n_bad++; $display("FAIL rnd_nwords frame=%0d got=%0d exp=%0d", f, got_data.size(), exp_data.size()); end
            n_cmp++; if (words_bad() !== 0) begin n_bad++; $display("FAIL rnd_words frame=%0d bad=%0d exp=0", f, words_bad()); end
            n_cmp++; if (req_cnt !== exp_total) begin n_bad++; $display("FAIL rnd_requests frame=%0d got=%0d exp=%0d", f, req_cnt, exp_total); end
            n_cmp++; if (ovf_cnt !== 0 || viol_cnt !== 0 || done_cnt !== 1)
                begin n_bad++; $display("FAIL rnd_protocol frame=%0d ovf=%0d viol=%0d done=%0d exp=0/0/1", f, ovf_cnt, viol_cnt, done_cnt); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_len7(0, 1'b0);
        test_len7(1, 1'b1);
        test_aligned();
        test_overlen();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
